// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter : round-robin, burst-bounded write arbiter feeding one FIFO
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo_wr_arbiter #(
    parameter int N_REQ = 4,
    parameter int SIZE  = 8,
    parameter int BURST = 4,
    parameter int GW    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*SIZE-1:0]   req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_enw,
    output logic [SIZE-1:0]         fifo_datain,
    output logic [GW-1:0]           grant_id,
    output logic                    busy
);

    localparam int             CW        = $clog2(BURST + 1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(BURST - 1);
    localparam logic [GW:0]    N_REQ_W   = (GW + 1)'(N_REQ);
    localparam logic [GW-1:0]  LAST_PORT = GW'(N_REQ - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state_q,    state_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] rr_ptr_q,   rr_ptr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    logic          w_found;
    logic [GW-1:0] w_pick;
    logic [GW:0]   w_idx;
    logic          w_gnt_valid;
    logic [GW-1:0] w_next_ptr;

    // Search starts at rr_ptr and wraps modulo N_REQ (N_REQ need not be a power of two).
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, rr_ptr_q} + (GW + 1)'(k);
            if (w_idx >= N_REQ_W) begin
                w_idx = w_idx - N_REQ_W;
            end
            if (!w_found && req_valid[w_idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[GW-1:0];
            end
        end
    end

    assign w_gnt_valid = req_valid[grant_id_q];
    assign w_next_ptr  = (grant_id_q == LAST_PORT) ? '0 : grant_id_q + GW'(1);

    assign busy        = (state_q == GRANT);
    assign grant_id    = grant_id_q;
    assign fifo_enw    = busy & w_gnt_valid & ~fifo_full;
    assign req_ready   = (busy && !fifo_full) ? (N_REQ'(1) << grant_id_q) : '0;
    assign fifo_datain = req_data[grant_id_q*SIZE +: SIZE];

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    grant_id_d = w_pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // A dropped valid ends the grant even while the FIFO is full.
                if (!w_gnt_valid || (fifo_enw && (beat_cnt_q == LAST_BEAT))) begin
                    state_d  = IDLE;
                    rr_ptr_d = w_next_ptr;
                end else if (fifo_enw) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// tb_fifo_wr_arbiter : self-checking bench for fifo_wr_arbiter (BURST=4 and 1)
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int N      = 4;
    localparam int SZ     = 8;
    localparam int FDEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*SZ-1:0] req_data;
    logic            fifo_full;

    logic [N-1:0]  rdy0, rdy1;
    logic          enw0, enw1, busy0, busy1;
    logic [SZ-1:0] dat0, dat1;
    logic [1:0]    gid0, gid1;

    logic          sel;
    logic [N-1:0]  o_rdy;
    logic          o_enw, o_busy;
    logic [SZ-1:0] o_dat;
    logic [1:0]    o_gid;

    assign o_rdy  = sel ? rdy1  : rdy0;
    assign o_enw  = sel ? enw1  : enw0;
    assign o_busy = sel ? busy1 : busy0;
    assign o_dat  = sel ? dat1  : dat0;
    assign o_gid  = sel ? gid1  : gid0;

    fifo_wr_arbiter #(.N_REQ(N), .SIZE(SZ), .BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy0), .fifo_full(fifo_full), .fifo_enw(enw0),
        .fifo_datain(dat0), .grant_id(gid0), .busy(busy0)
    );

    fifo_wr_arbiter #(.N_REQ(N), .SIZE(SZ), .BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy1), .fifo_full(fifo_full), .fifo_enw(enw1),
        .fifo_datain(dat1), .grant_id(gid1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef logic [SZ-1:0] dq_t[$];
    dq_t           pq[N];
    logic [SZ-1:0] fq[$];
    logic [N-1:0]  offer, mute;
    bit            gap_en, pop_once, force_full;
    int            pop_mode;
    int            trace[$];

    // Reference: is a grant open, who holds it, beats done in it, whose turn is next.
    int m_busy, m_gid, m_ptr, m_beats;

    typedef struct {
        logic [N-1:0]  v;
        logic [SZ-1:0] d2;
        logic          f;
        logic          busy;
        logic [1:0]    gid;
        logic [N-1:0]  rdy;
        logic          enw;
        logic [SZ-1:0] dat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = offer[i];
            req_data[i*SZ +: SZ]  = (pq[i].size() != 0) ? pq[i][0] : '0;
        end
        fifo_full = force_full || (fq.size() >= FDEPTH);
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() != 0) return 1'b1;
        end
        return m_busy != 0;
    endfunction

    function automatic int nwrites();
        int c = 0;
        foreach (trace[i]) if (trace[i] >= 0) c++;
        return c;
    endfunction

    task automatic load(input int p, input int n, input int base);
        for (int j = 0; j < n; j++) pq[p].push_back(SZ'(base + j));
        offer[p] = 1'b1;
    endtask

    // One clock: check at the falling edge, advance model, then update the environment.
    task automatic tick();
        int            burst;
        logic [N-1:0]  v, acc;
        logic          full_s, enw_s, exp_enw, found;
        logic [SZ-1:0] dat_s;
        @(negedge clk);
        burst  = sel ? 1 : 4;
        v      = req_valid;
        full_s = fifo_full;
        chk("busy", {31'd0, o_busy}, m_busy);
        chk("grant_id", {30'd0, o_gid}, m_gid);
        chk("req_ready", {28'd0, o_rdy}, (m_busy != 0 && !full_s) ? (32'd1 << m_gid) : 32'd0);
        exp_enw = (m_busy != 0) && v[m_gid] && !full_s;
        chk("fifo_enw", {31'd0, o_enw}, {31'd0, exp_enw});
        if (exp_enw && pq[m_gid].size() != 0)
            chk("fifo_datain", {24'd0, o_dat}, {24'd0, pq[m_gid][0]});
        trace.push_back(o_enw ? int'(o_gid) : -1);
        acc   = o_rdy & v;
        enw_s = o_enw;
        dat_s = o_dat;
        if (m_busy == 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && v[c]) begin
                    found = 1'b1; m_gid = c; m_beats = 0; m_busy = 1;
                end
            end
        end else begin
            if (exp_enw) m_beats++;
            if (!v[m_gid] || m_beats == burst) begin
                m_busy = 0;
                m_ptr  = (m_gid + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        if (enw_s) fq.push_back(dat_s);
        if (fq.size() != 0 && (pop_once || pop_mode == 1 ||
                               (pop_mode == 2 && $urandom_range(0, 2) == 0)))
            void'(fq.pop_front());
        pop_once = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(pq[i].pop_front());
            if (pq[i].size() == 0 || mute[i])  offer[i] = 1'b0;
            else if (!gap_en)                  offer[i] = 1'b1;
            else if (acc[i])                   offer[i] = ($urandom_range(0, 3) != 0);
            else if (!offer[i])                offer[i] = ($urandom_range(0, 2) == 0);
        end
        drive();
    endtask

    task automatic run_until_done(input string name, input int maxc);
        int n = 0;
        while (pending() && n < maxc) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, {31'd0, pending()}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        offer = '0; mute = '0;
        for (int i = 0; i < N; i++) pq[i].delete();
        fq.delete();
        trace.delete();
        force_full = 1'b0; pop_once = 1'b0; gap_en = 1'b0; pop_mode = 1;
        drive();
        #2;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_enw", {31'd0, o_enw}, 32'd0);
        chk("rst_ready", {28'd0, o_rdy}, 32'd0);
        chk("rst_gid", {30'd0, o_gid}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_busy = 0; m_gid = 0; m_ptr = 0; m_beats = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   w[$];
        int   exp_c[12];
        int   exp_w[9];
        int   exp_r[6];
        int   f;

        // Single producer on port 2: three beats, valid drop, then turn passes to port 3.
        tbl[0] = '{4'h4, 8'h11, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00};
        tbl[1] = '{4'h4, 8'h11, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 8'h11};
        tbl[2] = '{4'h4, 8'h22, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 8'h22};
        tbl[3] = '{4'h4, 8'h33, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 8'h33};
        tbl[4] = '{4'h0, 8'h00, 1'b0, 1'b1, 2'd2, 4'h4, 1'b0, 8'h00};
        tbl[5] = '{4'h0, 8'h00, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0, 8'h00};
        tbl[6] = '{4'hF, 8'h00, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0, 8'h00};
        tbl[7] = '{4'hF, 8'h00, 1'b0, 1'b1, 2'd3, 4'h8, 1'b1, 8'h00};
        exp_c = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
        exp_w = '{3, -1, 0, -1, 1, -1, 2, -1, 3};
        exp_r = '{0, 0, 1, 1, 1, 1};

        sel = 1'b0;
        do_reset();
        foreach (tbl[r]) begin
            req_valid = tbl[r].v;
            req_data  = '0;
            req_data[2*SZ +: SZ] = tbl[r].d2;
            fifo_full = tbl[r].f;
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", r), {31'd0, o_busy}, {31'd0, tbl[r].busy});
            chk($sformatf("tbl%0d_gid", r), {30'd0, o_gid}, {30'd0, tbl[r].gid});
            chk($sformatf("tbl%0d_ready", r), {28'd0, o_rdy}, {28'd0, tbl[r].rdy});
            chk($sformatf("tbl%0d_enw", r), {31'd0, o_enw}, {31'd0, tbl[r].enw});
            if (tbl[r].enw)
                chk($sformatf("tbl%0d_data", r), {24'd0, o_dat}, {24'd0, tbl[r].dat});
            @(posedge clk);
            #1;
        end

        // Contention: ports 0 and 1, six beats each.
        do_reset();
        load(0, 6, 'h00);
        load(1, 6, 'h10);
        drive();
        run_until_done("contention", 100);
        w.delete();
        foreach (trace[i]) if (trace[i] >= 0) w.push_back(trace[i]);
        chk("contention_count", w.size(), 12);
        for (int k = 0; k < 12; k++)
            if (k < w.size()) chk($sformatf("contention_order%0d", k), w[k], exp_c[k]);

        // Full backpressure: depth-4 FIFO with no reads, port 3 offers six beats.
        do_reset();
        pop_mode = 0;
        load(3, 6, 'h30);
        drive();
        repeat (8) tick();
        #1;
        chk("full_writes", nwrites(), 4);
        chk("full_busy", {31'd0, o_busy}, 32'd1);
        chk("full_gid", {30'd0, o_gid}, 32'd3);
        chk("full_enw", {31'd0, o_enw}, 32'd0);
        chk("full_ready", {28'd0, o_rdy}, 32'd0);
        pop_once = 1'b1;
        repeat (4) tick();
        chk("drain_one_write", nwrites(), 5);

        // Wrap and fairness with BURST=1, turn pointer pre-set to 3.
        sel = 1'b1;
        do_reset();
        load(2, 1, 'h20);
        drive();
        run_until_done("wrap_pre", 20);
        trace.delete();
        for (int i = 0; i < N; i++) load(i, 2, 'h40 + i * 16);
        drive();
        run_until_done("wrap", 100);
        f = -1;
        foreach (trace[i]) if (f < 0 && trace[i] >= 0) f = i;
        chk("wrap_first_found", {31'd0, f >= 0}, 32'd1);
        for (int k = 0; k < 9; k++)
            if (f >= 0 && f + k < trace.size())
                chk($sformatf("wrap_trace%0d", k), trace[f + k], exp_w[k]);

        // Reset in the middle of a burst.
        sel = 1'b0;
        do_reset();
        load(0, 1, 'h01);
        drive();
        run_until_done("rstmid_pre", 20);
        load(1, 6, 'h50);
        drive();
        for (int n = 0; n < 30 && nwrites() < 3; n++) tick();
        chk("rstmid_writes", nwrites(), 3);
        #2;
        chk("rstmid_pre_enw", {31'd0, o_enw}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstmid_enw", {31'd0, o_enw}, 32'd0);
        chk("rstmid_busy", {31'd0, o_busy}, 32'd0);
        chk("rstmid_ready", {28'd0, o_rdy}, 32'd0);
        chk("rstmid_gid", {30'd0, o_gid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_busy = 0; m_gid = 0; m_ptr = 0; m_beats = 0;
        trace.delete();
        load(0, 2, 'h60);
        drive();
        run_until_done("rstmid_post", 60);
        w.delete();
        foreach (trace[i]) if (trace[i] >= 0) w.push_back(trace[i]);
        chk("rstmid_post_count", w.size(), 6);
        for (int k = 0; k < 6; k++)
            if (k < w.size()) chk($sformatf("rstmid_order%0d", k), w[k], exp_r[k]);

        // Early exit: grantee drops valid while the FIFO is full.
        do_reset();
        load(0, 3, 'h70);
        force_full = 1'b1;
        drive();
        tick();
        tick();
        #1;
        chk("stall_busy", {31'd0, o_busy}, 32'd1);
        chk("stall_enw", {31'd0, o_enw}, 32'd0);
        mute[0] = 1'b1;
        offer[0] = 1'b0;
        drive();
        tick();
        #1;
        chk("early_exit_busy", {31'd0, o_busy}, 32'd0);
        chk("early_exit_writes", nwrites(), 0);
        mute[0] = 1'b0;
        offer[0] = 1'b1;
        load(1, 1, 'h80);
        force_full = 1'b0;
        drive();
        tick();
        #1;
        chk("early_exit_next_gid", {30'd0, o_gid}, 32'd1);
        chk("early_exit_next_busy", {31'd0, o_busy}, 32'd1);
        run_until_done("early_exit_post", 60);

        // Randomized traffic on both burst lengths against the reference model.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            gap_en   = 1'b1;
            pop_mode = 2;
            for (int i = 0; i < N; i++) begin
                int n;
                n = $urandom_range(3, 12);
                for (int j = 0; j < n; j++) pq[i].push_back(SZ'($urandom));
                offer[i] = 1'b1;
            end
            drive();
            run_until_done($sformatf("random%0d", s), 3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
